// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low segment codes,
// BCD digit width and an index-width helper.
package seg7_pkg;

    localparam int BCD_W = 4;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b1111110;
    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_bcd_decode.sv
// Combinational BCD to active-low {a,b,c,d,e,f,g} decoder; codes 10-15 show a dash.
module seg7_bcd_decode
    import seg7_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output seg_t             seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with tear-free frame latching
// and leading-zero blanking. Define SEG7_BLINK_EN to add per-digit blinking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int SCAN_DIV     = 1000
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [BCD_W*NUM_DIGITS-1:0] digits,
    input  logic                        load,
    input  logic                        lzb,
`ifdef SEG7_BLINK_EN
    input  logic [NUM_DIGITS-1:0]       blink_mask,
`endif
    output logic [6:0]                  seg,
    output logic [NUM_DIGITS-1:0]       an,
    output logic                        frame_done
);

    localparam int IDX_W = idx_width(NUM_DIGITS);
    localparam int CNT_W = idx_width(SCAN_DIV);
    localparam int DW    = BCD_W * NUM_DIGITS;

    logic [CNT_W-1:0]      scan_cnt_q, scan_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DW-1:0]         pending_q, pending_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end;
    logic                  boundary;
    logic [BCD_W-1:0]      cur_digit;
    seg_t                  cur_seg;
    logic                  lead_zero;
    logic                  blink_off;
    logic [NUM_DIGITS:0]   upper_zero;

    always_comb begin
        slot_end   = enable && (scan_cnt_q == CNT_W'(SCAN_DIV - 1));
        boundary   = slot_end && (idx_q == IDX_W'(NUM_DIGITS - 1));
        scan_cnt_d = scan_cnt_q;
        idx_d      = idx_q;
        if (enable) begin
            if (slot_end) begin
                scan_cnt_d = '0;
                idx_d      = boundary ? '0 : idx_q + IDX_W'(1);
            end else begin
                scan_cnt_d = scan_cnt_q + CNT_W'(1);
            end
        end
    end

    // A load coinciding with the boundary goes straight to the shadow so the
    // new value is never held back a whole frame.
    always_comb begin
        pending_d  = load ? digits : pending_q;
        shadow_d   = shadow_q;
        pend_vld_d = pend_vld_q;
        if (boundary) begin
            pend_vld_d = 1'b0;
            if (load) begin
                shadow_d = digits;
            end else if (pend_vld_q) begin
                shadow_d = pending_q;
            end
        end else if (load) begin
            pend_vld_d = 1'b1;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BF_W = idx_width(BLINK_FRAMES);

    logic [BF_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (boundary) begin
            if (blink_cnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BF_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`endif

    // upper_zero[i] is set when digit i and every digit above it are zero.
    always_comb begin
        upper_zero[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            upper_zero[i] = upper_zero[i+1] && (shadow_q[BCD_W*i +: BCD_W] == '0);
        end
        cur_digit = '0;
        lead_zero = 1'b0;
        blink_off = 1'b0;
        an_d      = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = shadow_q[BCD_W*i +: BCD_W];
                lead_zero = lzb && (i != 0) && upper_zero[i];
`ifdef SEG7_BLINK_EN
                blink_off = phase_q && blink_mask[i];
`endif
                an_d[i]   = ~enable;
            end
        end
        seg_d        = SEG_BLANK;
        if (enable && !lead_zero && !blink_off) begin
            seg_d = cur_seg;
        end
        frame_done_d = boundary;
    end

    seg7_bcd_decode u_decode (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt_q   <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            shadow_q     <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
